// File: rtl/affine_pred_collector_pkg.sv
// Shared constants for the affine prediction collector: pixel rounding
// parameters and the packed block geometry.
package affine_pred_collector_pkg;
    localparam int PRED_SHIFT  = 6;
    localparam int PRED_OFFSET = 32;
    localparam int PIX_MAX     = 255;
    localparam int PIX_W       = 8;
    localparam int INTERM_W    = 14;
    localparam int BLK_W       = 128;
    localparam int ROW_W       = 4 * PIX_W;
endpackage

// File: rtl/pred_block_fifo.sv
// Synchronous first-word-fall-through FIFO for completed prediction blocks.
// A push while full is accepted only when a pop happens on the same edge.
module pred_block_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 133
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/affine_pred_collector.sv
// Collects interpolated rows, rounds/clips them to 8-bit pixels, assembles
// 4x4 predicted sub-blocks and queues them for the residual/SAD consumer.
module affine_pred_collector
    import affine_pred_collector_pkg::*;
#(
    parameter int FIFO_DEPTH    = 2,
    parameter int NUM_SUBBLOCKS = 16,
    parameter int IDX_W         = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                FLAG_INT_OUT,
    input  logic                DONE_ALL,
    input  logic [INTERM_W-1:0] INTERP_OUT_0,
    input  logic [INTERM_W-1:0] INTERP_OUT_1,
    input  logic [INTERM_W-1:0] INTERP_OUT_2,
    input  logic [INTERM_W-1:0] INTERP_OUT_3,
    output logic [BLK_W-1:0]    OUT_BLOCK,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [IDX_W-1:0]    OUT_BLK_IDX,
    output logic                OUT_LAST,
    output logic                OVERFLOW,
    output logic                ERR_PARTIAL,
    output logic [1:0]          TB_ROW_COUNT
);
    localparam int ENT_W = BLK_W + IDX_W + 1;

    function automatic logic [PIX_W-1:0] round_clip(input logic [INTERM_W-1:0] v);
        logic [INTERM_W:0] sum;
        logic [INTERM_W:0] p;
        sum = {1'b0, v} + (INTERM_W + 1)'(PRED_OFFSET);
        p   = sum >> PRED_SHIFT;
        if (p > (INTERM_W + 1)'(PIX_MAX)) return PIX_W'(PIX_MAX);
        return p[PIX_W-1:0];
    endfunction

    logic [ROW_W-1:0] row_pix;
    logic [ROW_W-1:0] row0_q, row1_q, row2_q;
    logic [1:0]       row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             blk_done, fifo_pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0] fifo_din, fifo_dout;

    assign row_pix  = {round_clip(INTERP_OUT_3), round_clip(INTERP_OUT_2),
                       round_clip(INTERP_OUT_1), round_clip(INTERP_OUT_0)};
    assign blk_done = FLAG_INT_OUT && (row_cnt_q == 2'd3);
    assign fifo_pop = OUT_VALID && OUT_READY;
    assign fifo_din = {(blk_cnt_q == IDX_W'(NUM_SUBBLOCKS - 1)), blk_cnt_q,
                       row_pix, row2_q, row1_q, row0_q};

    always_comb begin
        row_cnt_d = row_cnt_q;
        blk_cnt_d = blk_cnt_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        if (FLAG_INT_OUT) begin
            row_cnt_d = row_cnt_q + 2'd1;
            if (blk_done) begin
                blk_cnt_d = (blk_cnt_q == IDX_W'(NUM_SUBBLOCKS - 1)) ? '0 : blk_cnt_q + IDX_W'(1);
                if (fifo_full && !fifo_pop) ovf_d = 1'b1;
            end
        end
        // The row captured this cycle counts before DONE_ALL flushes the block.
        if (DONE_ALL) begin
            if (row_cnt_d != 2'd0) err_d = 1'b1;
            row_cnt_d = '0;
            blk_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_cnt_q <= '0;
            blk_cnt_q <= '0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (FLAG_INT_OUT) begin
            case (row_cnt_q)
                2'd0:    row0_q <= row_pix;
                2'd1:    row1_q <= row_pix;
                2'd2:    row2_q <= row_pix;
                default: ;
            endcase
        end
    end

    pred_block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (blk_done),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Outputs read zero whenever nothing is queued.
    assign OUT_VALID    = !fifo_empty;
    assign OUT_BLOCK    = OUT_VALID ? fifo_dout[BLK_W-1:0] : '0;
    assign OUT_BLK_IDX  = OUT_VALID ? fifo_dout[BLK_W +: IDX_W] : '0;
    assign OUT_LAST     = OUT_VALID && fifo_dout[ENT_W-1];
    assign OVERFLOW     = ovf_q;
    assign ERR_PARTIAL  = err_q;
    assign TB_ROW_COUNT = row_cnt_q;
endmodule

// File: doc/affine_pred_collector.md
Name: affine_pred_collector

Overview:
- Sits downstream of the interpolator and control FSM and consumes their outputs.
- Captures each 4-sample interpolated row (INTERP_OUT_0..3), qualified by FLAG_INT_OUT.
- Rounds and clips each 14-bit intermediate sample to an 8-bit predicted pixel and assembles 4 rows into a 4x4 predicted sub-block.
- Hands finished sub-blocks to the consumer (residual/SAD stage) over a valid/ready interface, through a small block FIFO. The interpolator cannot stall, so lost blocks are flagged rather than back-pressured.

Parameters:
- FIFO_DEPTH, 2, number of completed 4x4 blocks buffered (power of 2, ≥1).
- NUM_SUBBLOCKS, 16, sub-blocks per CU; sets which block carries LAST.
- IDX_W, 4, width of the block index (must hold NUM_SUBBLOCKS-1).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- FLAG_INT_OUT  in  1  interpolated row valid this cycle.
- DONE_ALL  in  1  CU finished pulse from control.
- INTERP_OUT_0  in  14  row sample, column 0 (unsigned intermediate).
- INTERP_OUT_1  in  14  row sample, column 1.
- INTERP_OUT_2  in  14  row sample, column 2.
- INTERP_OUT_3  in  14  row sample, column 3.
- OUT_BLOCK  out  128  4x4 pixels; pixel (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)].
- OUT_VALID  out  1  OUT_BLOCK valid.
- OUT_READY  in  1  consumer accepts when OUT_VALID & OUT_READY.
- OUT_BLK_IDX  out  IDX_W  raster index of the block within the CU.
- OUT_LAST  out  1  block index == NUM_SUBBLOCKS-1.
- OVERFLOW  out  1  sticky; a completed block was dropped because the FIFO was full.
- ERR_PARTIAL  out  1  sticky; DONE_ALL arrived with 1..3 rows pending.
- TB_ROW_COUNT  out  2  rows currently assembled (debug).

Behaviour:
- Reset (RESET=1 at a clock edge): row count 0, block counter 0, FIFO empty, OVERFLOW=0, ERR_PARTIAL=0, OUT_VALID=0, OUT_BLOCK=0, OUT_BLK_IDX=0, OUT_LAST=0. Reset mid-block discards all partial and buffered data.
- Rounding, per sample: p = (v + 32) >> 6, computed at 15-bit width. If p > 255 then p = 255.
  - Examples: 0→0, 31→0, 32→1, 6400→100, 16383→255.
- Row capture: on an edge with FLAG_INT_OUT=1, the 4 rounded pixels are written into assembly row[row_count], and row_count increments.
- Block completion: when the captured row is row 3, the full block {rows 0..3} and the current block counter are pushed to the FIFO at that same edge. row_count wraps to 0 and the block counter increments.
  - The block counter wraps to 0 after NUM_SUBBLOCKS-1.
- Latency: OUT_VALID rises the cycle after the edge that captured row 3, provided the FIFO was empty (first-word-fall-through).
- FIFO full at push:
  - If a pop happens the same cycle (OUT_VALID & OUT_READY), the push succeeds.
  - Otherwise the new block is dropped, OVERFLOW is set, and the block counter still increments so indices stay aligned with CU position.
- Handshake:
  - OUT_BLOCK, OUT_BLK_IDX and OUT_LAST are stable while OUT_VALID=1 and OUT_READY=0.
  - A pop occurs on an edge with OUT_VALID & OUT_READY; the next entry is presented the following cycle.
  - OUT_VALID never drops without a pop.
- DONE_ALL:
  - When DONE_ALL=1 on an edge, any row captured that same cycle is processed first.
  - If row_count is nonzero after that processing, ERR_PARTIAL is set and the partial block is discarded.
  - row_count and the block counter are then cleared. FIFO contents are kept and still drained normally.
- Sticky flags clear only on RESET.

Decomposition:
- Shared package holds the constants: PRED_SHIFT=6, PRED_OFFSET=32, PIX_MAX=255, PIX_W=8, INTERM_W=14, BLK_W=128.
- One sub-module: pred_block_fifo.
  - Synchronous FWFT FIFO, FIFO_DEPTH entries of (BLK_W+IDX_W+1) bits.
  - Ports: push, pop, full, empty, din, dout.
  - Simultaneous push and pop are allowed when full.
- Rounding, assembly, counters and flags stay in the top.

Test Plan:
- Single block: 4 rows, FLAG_INT_OUT every cycle, each row {6400,32,31,16383}, OUT_READY=1 → OUT_VALID rises 1 cycle after row 3. Every row is bytes {100,1,0,255}. OUT_BLK_IDX=0, OUT_LAST=0, no flags set.
- Full CU: 64 rows with OUT_READY=1 → 16 blocks, OUT_BLK_IDX 0..15, OUT_LAST=1 only on index 15, counter back at 0.
- Back-pressure with FIFO_DEPTH=2: OUT_READY=0 for 3 completed blocks → blocks 0 and 1 held, block 2 dropped, OVERFLOW=1. After OUT_READY=1, exactly blocks 0 and 1 are delivered. A 4th block delivers with OUT_BLK_IDX=3.
- Full FIFO with simultaneous pop and push: the push is accepted and OVERFLOW stays 0.
- DONE_ALL after 2 rows → ERR_PARTIAL=1, TB_ROW_COUNT=0, no block output. DONE_ALL in the same cycle as row 3 → block emitted, ERR_PARTIAL stays 0.
- RESET asserted with 2 rows pending and 1 block in the FIFO → next cycle OUT_VALID=0, TB_ROW_COUNT=0, flags 0. A following 4-row block emits with OUT_BLK_IDX=0.
